fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 11 +
 rtl/fb_arbiter_cmd_fifo.sv | 40 ++++
 rtl/fb_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer widths, writer command type and grant encoding.
package fb_pkg;
  localparam int FB_AW = 15;
  localparam int FB_DW = 12;
  typedef struct packed {
    logic             we;
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] wdata;
  } fb_cmd_t;
  typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_CMD} gnt_e;
endpackage

// File: rtl/fb_arbiter_cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with full/empty flags; refuses pushes while full.
module cmd_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rp];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + PW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + PW'(1) : r_rp;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between display fetches
// (strict priority) and a FIFO-buffered writer command stream.
module fb_arbiter import fb_pkg::*; #(
  parameter int AW          = FB_AW,
  parameter int DW          = FB_DW,
  parameter int FIFO_DEPTH  = 4,
  parameter int VBLANK_ONLY = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          display_on_i,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic          disp_valid_o,
  output logic [DW-1:0] disp_data_o,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic [15:0]   stall_cnt_o
);
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
  cmd_t        w_in, w_head;
  logic        w_full, w_empty, w_push, w_cmd_ok;
  gnt_e        w_gnt;
  logic        r_disp_v, r_rsp_v;
  logic [15:0] r_stall;
  assign w_in        = {cmd_we_i, cmd_addr_i, cmd_wdata_i};
  assign cmd_ready_o = !w_full && !rst_i;
  assign w_push      = cmd_valid_i && cmd_ready_o;
  cmd_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_gnt == GNT_CMD),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign w_cmd_ok = !w_empty && (VBLANK_ONLY == 0 || !display_on_i);
  // Reset forces the bus idle so nothing touches the RAM while rst_i is high.
  always_comb begin
    w_gnt = rst_i ? GNT_IDLE : disp_req_i ? GNT_DISP : w_cmd_ok ? GNT_CMD : GNT_IDLE;
  end
  assign ram_en_o     = w_gnt != GNT_IDLE;
  assign ram_we_o     = w_gnt == GNT_CMD && w_head.we;
  assign ram_addr_o   = w_gnt == GNT_DISP ? disp_addr_i : w_head.addr;
  assign ram_wdata_o  = ram_we_o ? w_head.wdata : '0;
  assign disp_valid_o = r_disp_v;
  assign rsp_valid_o  = r_rsp_v;
  assign disp_data_o  = ram_rdata_i;
  assign rsp_data_o   = ram_rdata_i;
  assign stall_cnt_o  = r_stall;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_disp_v <= 1'b0;
      r_rsp_v  <= 1'b0;
      r_stall  <= '0;
    end else begin
      r_disp_v <= w_gnt == GNT_DISP;
      r_rsp_v  <= w_gnt == GNT_CMD && !w_head.we;
      if (!w_empty && w_gnt != GNT_CMD && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end
  end
endmodule
